decode_stage: RTL

//  RV32I decode stage: consumes InstrD/PCD/PCPlus4D from fetch, reads the 32x32 register file,

---
 rtl/decode_stage.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: register file with write-back bypass, immediate extension,
// control generation and the ID/EX pipeline register feeding execute.
module decode_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            ALUSrcE,
    output logic            BranchE,
    output logic            JumpE,
    output logic            JalrE,
    output logic [1:0]      ResultSrcE,
    output logic [3:0]      ALUControlE,
    output logic            IllegalE
);
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = NOP_INSTR[6:0];
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE= 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR   = 4'h3,
                           ALU_XOR = 4'h4, ALU_SLT = 4'h5, ALU_SLTU = 4'h6, ALU_SLL = 4'h7,
                           ALU_SRL = 4'h8, ALU_SRA = 4'h9, ALU_PASSB = 4'hA;

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memwrite;
        logic            alusrc;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic [1:0]      resultsrc;
        logic [3:0]      aluctl;
        logic            illegal;
    } idex_t;

    idex_t           idex_d, idex_q;
    logic [XLEN-1:0] rf_q [32];
    logic [6:0]      op;
    logic [2:0]      f3;
    logic            f7b5;
    logic            wb_en;
    logic [3:0]      alu_f3;

    assign op    = InstrD[6:0];
    assign f3    = InstrD[14:12];
    assign f7b5  = InstrD[30];
    assign Rs1D  = InstrD[19:15];
    assign Rs2D  = InstrD[24:20];
    assign wb_en = RegWriteW && (RdW != 5'd0);

    // Shared R/I-ALU function select; the add/sub split is R-type only.
    always_comb begin
        alu_f3 = ALU_ADD;
        case (f3)
            3'b000: alu_f3 = (op == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_f3 = ALU_SLL;
            3'b010: alu_f3 = ALU_SLT;
            3'b011: alu_f3 = ALU_SLTU;
            3'b100: alu_f3 = ALU_XOR;
            3'b101: alu_f3 = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin
        idex_d     = '0;
        idex_d.pc  = PCD;
        idex_d.pc4 = PCPlus4D;
        idex_d.rs1 = Rs1D;
        idex_d.rs2 = Rs2D;
        idex_d.rd  = InstrD[11:7];
        // Bypass lets the ID/EX register catch a value being written this same edge.
        if (Rs1D == 5'd0)                  idex_d.rd1 = '0;
        else if (wb_en && RdW == Rs1D)     idex_d.rd1 = ResultW;
        else                               idex_d.rd1 = rf_q[Rs1D];
        if (Rs2D == 5'd0)                  idex_d.rd2 = '0;
        else if (wb_en && RdW == Rs2D)     idex_d.rd2 = ResultW;
        else                               idex_d.rd2 = rf_q[Rs2D];

        case (op)
            OP_R: begin
                idex_d.regwrite = 1'b1;
                idex_d.aluctl   = alu_f3;
            end
            OP_IALU: begin
                idex_d.regwrite = 1'b1;
                idex_d.alusrc   = 1'b1;
                idex_d.aluctl   = alu_f3;
                idex_d.imm      = {{20{InstrD[31]}}, InstrD[31:20]};
            end
            OP_LOAD: begin
                idex_d.regwrite  = 1'b1;
                idex_d.alusrc    = 1'b1;
                idex_d.resultsrc = 2'b01;
                idex_d.imm       = {{20{InstrD[31]}}, InstrD[31:20]};
            end
            OP_STORE: begin
                idex_d.memwrite = 1'b1;
                idex_d.alusrc   = 1'b1;
                idex_d.imm      = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            end
            OP_BR: begin
                idex_d.branch = 1'b1;
                idex_d.aluctl = ALU_SUB;
                idex_d.imm    = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                                 InstrD[11:8], 1'b0};
            end
            OP_JAL: begin
                idex_d.jump      = 1'b1;
                idex_d.regwrite  = 1'b1;
                idex_d.resultsrc = 2'b10;
                idex_d.imm       = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                                    InstrD[30:21], 1'b0};
            end
            OP_JALR: begin
                idex_d.jump      = 1'b1;
                idex_d.jalr      = 1'b1;
                idex_d.regwrite  = 1'b1;
                idex_d.alusrc    = 1'b1;
                idex_d.resultsrc = 2'b10;
                idex_d.imm       = {{20{InstrD[31]}}, InstrD[31:20]};
            end
            OP_LUI: begin
                idex_d.regwrite = 1'b1;
                idex_d.alusrc   = 1'b1;
                idex_d.aluctl   = ALU_PASSB;
                idex_d.imm      = {InstrD[31:12], 12'b0};
            end
            default: idex_d.illegal = (InstrD != 32'h0);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            if (FlushE)       idex_q <= '0;
            else if (!StallE) idex_q <= idex_d;
            if (wb_en) rf_q[RdW] <= ResultW;
        end
    end

    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc4;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;
    assign RdE         = idex_q.rd;
    assign RegWriteE   = idex_q.regwrite;
    assign MemWriteE   = idex_q.memwrite;
    assign ALUSrcE     = idex_q.alusrc;
    assign BranchE     = idex_q.branch;
    assign JumpE       = idex_q.jump;
    assign JalrE       = idex_q.jalr;
    assign ResultSrcE  = idex_q.resultsrc;
    assign ALUControlE = idex_q.aluctl;
    assign IllegalE    = idex_q.illegal;
endmodule
